delay_capture_ctrl: RTL and testbench

//   Stage upstream of the 8-bit output counter: measures clk cycles between a

---
 rtl/delay_capture_ctrl.sv | 135 +++++++++++++
 tb/tb_delay_capture_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : delay_capture_ctrl
//  Purpose  : Measures the number of clk cycles between a rising edge on the
//             raw start pin and a rising edge on the raw stop pin. Both pins
//             are synchronized internally. The count is held on result under
//             a valid/ack handshake so the downstream output counter can load
//             it.
//  Ports    : clk      - system clock
//             rst      - asynchronous reset, active-high
//             en       - block enable
//             start_in - raw start pin (asynchronous)
//             stop_in  - raw stop pin (asynchronous)
//             ack      - consumer took result (only meaningful while valid)
//             result   - measured cycle count, held while valid
//             valid    - result available
//             busy     - measurement in progress
//             overflow - measurement saturated without a stop edge
//  Revision : 1.0 - initial release
// ============================================================================
module delay_capture_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             ack,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   overflow_q, overflow_d;

  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] stop_sync_q;
  logic                   start_prev_q;
  logic                   stop_prev_q;
  logic                   start_rise;
  logic                   stop_rise;

  // Synchronizers and edge detectors. Both paths have identical depth, so
  // the latency cancels out of the measured difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_in};
      stop_sync_q  <= {stop_sync_q[SYNC_STAGES-2:0], stop_in};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      stop_prev_q  <= stop_sync_q[SYNC_STAGES-1];
    end
  end

  assign start_rise = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign stop_rise  = stop_sync_q[SYNC_STAGES-1]  & ~stop_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        // The start edge itself is cycle 1, so a stop one cycle later reads 1.
        if (en && start_rise) begin
          state_d    = COUNT;
          cnt_d      = WIDTH'(1);
          overflow_d = 1'b0;
        end
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (stop_rise) begin
          // A stop on the saturating cycle still counts as a real stop.
          result_d = cnt_q;
          state_d  = DONE;
        end else if (cnt_q == {WIDTH{1'b1}}) begin
          result_d   = {WIDTH{1'b1}};
          overflow_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode directly from registers.
  assign result   = result_q;
  assign overflow = overflow_q;
  assign valid    = (state_q == DONE);
  assign busy     = (state_q == COUNT);

endmodule
`default_nettype wire

// File: tb/tb_delay_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_capture_ctrl
//  Purpose  : Directed self-checking bench for delay_capture_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delay_capture_ctrl;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst     = 1'b1;
  logic       en      = 1'b0;
  logic       start_in = 1'b0;
  logic       stop_in  = 1'b0;
  logic       ack     = 1'b0;
  logic [7:0] result;
  logic       valid;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 if (clk_run) clk = ~clk;

  delay_capture_ctrl #(
    .WIDTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start_in (start_in),
    .stop_in  (stop_in),
    .ack      (ack),
    .result   (result),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_valid(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (valid) break;
      step();
    end
    check(tag, 32'(valid), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (busy) break;
      step();
    end
    check(tag, 32'(busy), 32'd1);
  endtask

  task automatic lower_pins();
    start_in = 1'b0;
    stop_in  = 1'b0;
    steps(4);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check(tag, 32'(valid), 32'd0);
  endtask

  initial begin
    // Reset state
    steps(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    steps(2);

    // 1: stop 10 cycles after start
    start_in = 1'b1;
    steps(10);
    stop_in = 1'b1;
    wait_valid("t1_valid", 40);
    check("t1_result", 32'(result), 32'd10);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 4: extra edges while holding result are dropped
    lower_pins();
    start_in = 1'b1;
    steps(3);
    stop_in = 1'b1;
    steps(6);
    check("t4_hold_result", 32'(result), 32'd10);
    check("t4_hold_valid", 32'(valid), 32'd1);
    lower_pins();
    check("t4_hold_busy", 32'(busy), 32'd0);
    do_ack("t4_ack_valid");
    // New start accepted; stop one cycle later gives 1
    start_in = 1'b1;
    step();
    stop_in = 1'b1;
    wait_valid("t4_new_valid", 40);
    check("t4_new_result", 32'(result), 32'd1);
    lower_pins();
    do_ack("t4_ack2_valid");

    // 2: no stop edge -> saturation after 255 cycles
    start_in = 1'b1;
    wait_busy("t2_busy", 10);
    n = 0;
    while (!valid && n < 400) begin
      step();
      n++;
    end
    check("t2_cycles", 32'(n), 32'd255);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_result", 32'(result), 32'hFF);
    check("t2_ovf", 32'(overflow), 32'd1);
    lower_pins();
    do_ack("t2_ack_valid");

    // 3a: stop at 254 -> 254, no overflow
    start_in = 1'b1;
    steps(254);
    stop_in = 1'b1;
    wait_valid("t3a_valid", 40);
    check("t3a_result", 32'(result), 32'd254);
    check("t3a_ovf", 32'(overflow), 32'd0);
    lower_pins();
    do_ack("t3a_ack_valid");

    // 3b: stop on the saturating cycle -> 255, no overflow
    start_in = 1'b1;
    steps(255);
    stop_in = 1'b1;
    wait_valid("t3b_valid", 40);
    check("t3b_result", 32'(result), 32'hFF);
    check("t3b_ovf", 32'(overflow), 32'd0);
    lower_pins();
    do_ack("t3b_ack_valid");

    // 5: en low during COUNT aborts, then a 3-cycle measurement
    start_in = 1'b1;
    wait_busy("t5_busy", 10);
    steps(5);
    en = 1'b0;
    steps(2);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_valid", 32'(valid), 32'd0);
    en = 1'b1;
    lower_pins();
    check("t5_idle_valid", 32'(valid), 32'd0);
    start_in = 1'b1;
    steps(3);
    stop_in = 1'b1;
    wait_valid("t5_valid", 40);
    check("t5_result", 32'(result), 32'd3);
    lower_pins();
    do_ack("t5_ack_valid");

    // 6: ack outside DONE ignored; async reset with clock stopped
    start_in = 1'b1;
    wait_busy("t6_busy", 10);
    steps(3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t6_ack_ignored", 32'(busy), 32'd1);
    @(negedge clk);
    #1 clk_run = 1'b0;
    #20 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_result", 32'(result), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    start_in = 1'b0;
    #20 rst = 1'b0;
    #5 clk_run = 1'b1;
    steps(4);
    check("t6_post_busy", 32'(busy), 32'd0);
    start_in = 1'b1;
    stop_in  = 1'b1;
    wait_busy("t6_both_busy", 10);
    steps(10);
    check("t6_stop_ignored_busy", 32'(busy), 32'd1);
    check("t6_stop_ignored_valid", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
